median_ctrl: RTL and testbench
==============================

MEDIAN_CTRL -- requirements
Module: median_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of one sample.
REQ-002 Parameter DATA_SIZE, default 9, samples per median window (odd, >=3).
REQ-003 Parameter MED_LATENCY, default 2, clock cycles from issue to a valid median result (>=1).
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rstn_i  input  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
REQ-006 in_valid_i  input  1  upstream sample valid.
REQ-007 in_data_i  input  DATA_WIDTH  upstream sample.
REQ-008 in_ready_o  output  1  controller accepts a sample this cycle.
REQ-009 flush_i  input  1  abort the current window; discard collected samples and any pending result.
REQ-010 win_o  output  DATA_SIZE x DATA_WIDTH unpacked array  window driven to the median datapath.
REQ-011 med_start_o  output  1  one-cycle strobe: win_o is complete and stable.
REQ-012 med_result_i  input  DATA_WIDTH  median returned by the datapath.
REQ-013 out_valid_o  output  1  out_data_o holds a median.
REQ-014 out_data_o  output  DATA_WIDTH  captured median.
REQ-015 out_ready_i  input  1  downstream accepts out_data_o.
REQ-016 busy_o  output  1  high in any state other than FILL.
REQ-017 frames_o  output  16  count of medians delivered; wraps 0xFFFF->0x0000.

Function
REQ-018 FSM states FILL, ISSUE, WAIT, OUT; only FILL accepts samples.
REQ-019 FILL: in_ready_o=1; on in_valid_i&&in_ready_o, win_o[cnt]<=in_data_i, cnt<=cnt+1 (cnt 0..DATA_SIZE-1).
REQ-020 FILL->ISSUE on the edge that accepts sample DATA_SIZE-1; cnt<=0 on that edge.
REQ-021 ISSUE: lasts exactly 1 cycle; med_start_o=1; in_ready_o=0; next state WAIT with latency counter<=MED_LATENCY.
REQ-022 WAIT: counter decrements each cycle; when counter==1, out_data_o<=med_result_i on that edge and state->OUT.
REQ-023 Consequently med_result_i is sampled on exactly the MED_LATENCY-th rising edge after the edge that exits ISSUE.
REQ-024 win_o holds its value unchanged from entry to ISSUE until return to FILL; it is written only in FILL.
REQ-025 OUT: out_valid_o=1, out_data_o stable; on out_ready_i=1, frames_o<=frames_o+1 and state->FILL.
REQ-026 OUT with out_ready_i=0: hold indefinitely; out_valid_o and out_data_o do not change.
REQ-027 Sample presented while in_ready_o=0 is not consumed; upstream must hold it.
REQ-028 flush_i=1 on any edge: state->FILL, cnt<=0, counter<=0, out_valid_o<=0; win_o and frames_o are not cleared; no sample is accepted that cycle.
REQ-029 flush_i has priority over sample acceptance and out_ready_i handshake in the same cycle; rstn_i has priority over flush_i.
REQ-030 med_start_o, out_valid_o, in_ready_o are decoded from registered state; no combinational path from any input to any output.
REQ-031 Minimum window period is DATA_SIZE+1+MED_LATENCY+1 cycles with in_valid_i and out_ready_i held high.

Reset
REQ-032 On rstn_i=0 at a rising edge: state=FILL, cnt=0, latency counter=0, every win_o element=0, out_data_o=0, out_valid_o=0, med_start_o=0, frames_o=0.
REQ-033 After reset in_ready_o=1 and busy_o=0 in the first cycle with rstn_i=1.
REQ-034 Reset mid-operation (any state) discards the window and any pending result, with identical values to REQ-032.

Verification
REQ-035 Stream 9,3,7,1,5,8,2,6,4 with in_valid_i continuous, MED_LATENCY=2, datapath model returns win_o[4] -> med_start_o high 1 cycle after 9th accept; out_data_o=5 and out_valid_o=1 3 cycles after the ISSUE edge.
REQ-036 Same stream, out_ready_i=0 for 10 cycles -> out_valid_o stays 1, out_data_o stays 5, in_ready_o=0, frames_o=0; then out_ready_i=1 -> frames_o=1, in_ready_o=1 next cycle.
REQ-037 in_valid_i toggling 1/0 each cycle -> only 9 accepts fill window; med_start_o occurs exactly once per 9 accepts.
REQ-038 flush_i after 5 samples, then 9 new samples 10..90 step 10 -> win_o={10..90}, out_data_o=50, no result from the aborted window.
REQ-039 rstn_i=0 during WAIT -> all outputs at REQ-032 values next cycle; no out_valid_o pulse afterwards without a new window.
REQ-040 frames_o preset near wrap by delivering 65536 windows -> frames_o reads 0x0000 after the 65536th handshake.

Source files
------------

// File: rtl/median_ctrl.sv
// Window-collecting controller for an external median datapath: gathers DATA_SIZE
// samples, strobes the datapath, waits MED_LATENCY cycles and holds the result for downstream.
module median_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_SIZE   = 9,
  parameter int MED_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] win_o [DATA_SIZE],
  output logic                  med_start_o,
  input  logic [DATA_WIDTH-1:0] med_result_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic [15:0]           frames_o
);

  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int LAT_W = $clog2(MED_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MED_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [LAT_W-1:0]      lat_q;
  logic [DATA_WIDTH-1:0] win_q [DATA_SIZE];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [15:0]           frames_q;

  // Controller FSM: window fill, datapath issue, latency wait and output hold
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      lat_q      <= '0;
      out_data_q <= '0;
      frames_q   <= 16'd0;
      for (int i = 0; i < DATA_SIZE; i++) begin
        win_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Window contents and frame count survive a flush; only progress is dropped
      state_q <= ST_FILL;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_valid_i) begin
            win_q[cnt_q] <= in_data_i;
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= ST_ISSUE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          lat_q   <= LAT_INIT;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_q == LAT_ONE) begin
            out_data_q <= med_result_i;
            lat_q      <= '0;
            state_q    <= ST_OUT;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            frames_q <= frames_q + 16'd1;
            state_q  <= ST_FILL;
          end
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_FILL);
  assign med_start_o = (state_q == ST_ISSUE);
  assign out_valid_o = (state_q == ST_OUT);
  assign busy_o      = (state_q != ST_FILL);
  assign out_data_o  = out_data_q;
  assign frames_o    = frames_q;
  assign win_o       = win_q;

endmodule

// File: tb/tb_median_ctrl.sv
// Self-checking bench for median_ctrl: directed scenarios plus a randomized run
// against a queue-based window/median scoreboard.
module tb_median_ctrl;
  localparam int DW = 8;
  localparam int DS = 9;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] win [DS];
  logic          med_start;
  logic [DW-1:0] med_result;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic [15:0]   frames;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [15:0]   frames_exp = 16'd0;
  logic [DW-1:0] pipe [ML];

  median_ctrl #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .MED_LATENCY(ML)) dut (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .flush_i(flush), .win_o(win), .med_start_o(med_start),
    .med_result_i(med_result), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .busy_o(busy), .frames_o(frames)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] med_q(input logic [DW-1:0] q [$]);
    logic [DW-1:0] t [$];
    t = q;
    t.sort();
    return t[DS/2];
  endfunction

  function automatic logic [DW-1:0] med_w(input logic [DW-1:0] w [DS]);
    logic [DW-1:0] t [$];
    for (int i = 0; i < DS; i++) t.push_back(w[i]);
    return med_q(t);
  endfunction

  // Datapath model: true median appears exactly ML edges after the strobe, junk otherwise
  always @(posedge clk) begin
    pipe[0] <= med_start ? med_w(win) : ~med_w(win);
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign med_result = pipe[ML-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input logic [DW-1:0] d [DS]);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < DS && guard < 100) begin
      in_valid = 1'b1;
      in_data  = d[i];
      if (in_ready) i++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (i != DS) begin
      n_err++;
      $display("FAIL push_window: accepted %0d, required %0d", i, DS);
    end
  endtask

  task automatic test_reset();
    int bad;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < DS; i++) if (win[i] !== 8'd0) bad++;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || med_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: rdy=%b busy=%b ov=%b ms=%b, required 1 0 0 0", in_ready, busy, out_valid, med_start);
    end
    n_cmp++;
    if (frames !== 16'd0 || out_data !== 8'd0 || bad != 0) begin
      n_err++;
      $display("FAIL reset_values: frames=%0d out_data=%0d nonzero_win=%0d, required 0 0 0", frames, out_data, bad);
    end
    frames_exp = 16'd0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] s [DS];
    int bad;
    s = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
    out_ready = 1'b0;
    push_window(s);
    in_valid = 1'b1; in_data = 8'hAA;
    n_cmp++;
    if (med_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_issue: ms=%b rdy=%b busy=%b, required 1 0 1", med_start, in_ready, busy);
    end
    bad = 0;
    for (int i = 0; i < DS; i++) if (win[i] !== s[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL basic_win: %0d elements differ, required 0", bad); end
    tick();
    n_cmp++;
    if (med_start !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_wait1: ms=%b ov=%b, required 0 0", med_start, out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait2: ov=%b, required 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'd5) begin
      n_err++;
      $display("FAIL basic_result: ov=%b data=%0d, required 1 5", out_valid, out_data);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'd5 || in_ready !== 1'b0 || frames !== 16'd0) begin
        n_err++;
        $display("FAIL basic_hold[%0d]: ov=%b data=%0d rdy=%b frames=%0d, required 1 5 0 0", k, out_valid, out_data, in_ready, frames);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    frames_exp = frames_exp + 16'd1;
    out_ready = 1'b0;
    n_cmp++;
    if (frames !== frames_exp || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_handshake: frames=%0d rdy=%b ov=%b, required %0d 1 0", frames, in_ready, out_valid, frames_exp);
    end
  endtask

  task automatic test_toggle();
    logic [DW-1:0] smp [$];
    logic [DW-1:0] exp [$];
    int acc;
    int starts;
    int outs;
    acc = 0; starts = 0; outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (med_start) starts++;
      in_valid = (c % 2 == 0);
      in_data  = 8'($urandom);
      if (in_valid && in_ready) begin
        acc++;
        smp.push_back(in_data);
        if (smp.size() == DS) begin exp.push_back(med_q(smp)); smp.delete(); end
      end
      if (out_valid && out_ready) begin
        outs++;
        frames_exp = frames_exp + 16'd1;
        n_cmp++;
        if (exp.size() == 0) begin
          n_err++; $display("FAIL toggle_data: unexpected result %0d, required none", out_data);
        end else if (out_data !== exp[0]) begin
          n_err++; $display("FAIL toggle_data: got %0d, required %0d", out_data, exp[0]);
        end
        if (exp.size() != 0) void'(exp.pop_front());
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc < DS || starts != acc / DS || outs != 1) begin
      n_err++;
      $display("FAIL toggle_starts: accepts=%0d starts=%0d outs=%0d, required starts=%0d outs=1", acc, starts, outs, acc / DS);
    end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] smp [$];
    logic [DW-1:0] exp [$];
    logic [DW-1:0] last_win [$];
    int t_s;
    bit pend;
    int bad;
    pend = 1'b0; t_s = 0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (in_ready && out_valid) begin
        n_cmp++; n_err++; $display("FAIL rand_excl: in_ready and out_valid both high at cycle %0d", c);
      end
      if (med_start) begin
        t_s = c; pend = 1'b1;
        bad = 0;
        for (int i = 0; i < DS; i++) if (last_win.size() != DS || win[i] !== last_win[i]) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL rand_win: %0d elements differ, required 0", bad); end
      end
      if (out_valid && pend) begin
        pend = 1'b0;
        n_cmp++;
        if (c - t_s != ML + 1) begin
          n_err++; $display("FAIL rand_latency: %0d cycles, required %0d", c - t_s, ML + 1);
        end
      end
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 1) != 0);
        flush     = ($urandom_range(0, 49) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      in_data = 8'($urandom);
      if (flush) begin
        smp.delete(); exp.delete(); pend = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          smp.push_back(in_data);
          if (smp.size() == DS) begin
            last_win = smp;
            exp.push_back(med_q(smp));
            smp.delete();
          end
        end
        if (out_valid && out_ready) begin
          frames_exp = frames_exp + 16'd1;
          n_cmp++;
          if (exp.size() == 0) begin
            n_err++; $display("FAIL rand_data: unexpected result %0d, required none", out_data);
          end else if (out_data !== exp[0]) begin
            n_err++; $display("FAIL rand_data: got %0d, required %0d", out_data, exp[0]);
          end
          if (exp.size() != 0) void'(exp.pop_front());
        end
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (exp.size() != 0 || frames !== frames_exp) begin
      n_err++;
      $display("FAIL rand_final: pending=%0d frames=%0d, required 0 %0d", exp.size(), frames, frames_exp);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] s [DS];
    int bad;
    bit got;
    for (int i = 0; i < DS; i++) s[i] = 8'(10 * (i + 1));
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = 8'($urandom); tick(); end
    flush = 1'b1; in_data = 8'hFF; tick(); flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || med_start !== 1'b0) begin
      n_err++; $display("FAIL flush_state: ov=%b rdy=%b ms=%b, required 0 1 0", out_valid, in_ready, med_start);
    end
    push_window(s);
    bad = 0;
    for (int i = 0; i < DS; i++) if (win[i] !== s[i]) bad++;
    n_cmp++;
    if (bad != 0 || med_start !== 1'b1) begin
      n_err++; $display("FAIL flush_win: %0d elements differ ms=%b, required 0 1", bad, med_start);
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) if (out_valid) got = 1'b1; else tick();
    n_cmp++;
    if (!got || out_data !== 8'd50) begin
      n_err++; $display("FAIL flush_result: valid_seen=%b data=%0d, required 1 50", got, out_data);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    frames_exp = frames_exp + 16'd1;
    n_cmp++;
    if (frames !== frames_exp) begin
      n_err++; $display("FAIL flush_frames: got %0d, required %0d", frames, frames_exp);
    end
  endtask

  task automatic test_reset_wait();
    logic [DW-1:0] s [DS];
    int bad;
    int seen;
    for (int i = 0; i < DS; i++) s[i] = 8'($urandom_range(1, 255));
    out_ready = 1'b1;
    push_window(s);
    tick();
    rstn = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < DS; i++) if (win[i] !== 8'd0) bad++;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || med_start !== 1'b0 ||
        frames !== 16'd0 || out_data !== 8'd0 || bad != 0) begin
      n_err++;
      $display("FAIL rst_wait: rdy=%b busy=%b ov=%b ms=%b frames=%0d data=%0d nonzero_win=%0d, required 1 0 0 0 0 0 0",
               in_ready, busy, out_valid, med_start, frames, out_data, bad);
    end
    rstn = 1'b1;
    frames_exp = 16'd0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid || med_start) seen++;
      tick();
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL rst_no_result: %0d active cycles, required 0", seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] s [DS];
    bit got;
    force dut.frames_q = 16'hFFFE;
    tick();
    release dut.frames_q;
    frames_exp = 16'hFFFE;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DS; i++) s[i] = 8'($urandom);
      push_window(s);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (out_valid) got = 1'b1;
        tick();
      end
      frames_exp = frames_exp + 16'd1;
      n_cmp++;
      if (!got || frames !== frames_exp) begin
        n_err++; $display("FAIL wrap[%0d]: valid_seen=%b frames=%h, required 1 %h", w, got, frames, frames_exp);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_random();
    test_flush();
    test_reset_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
